// File: rtl/gpmc_csr_bank.sv
// Control/status register bank on the GPMC host interface: ID, scratch, control
// levels and pulses, sticky W1C event flags with an IRQ mask, and saturating event counters.
module gpmc_csr_bank #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h0000,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 16'hC10D,
  parameter int                    N_SCRATCH   = 2,
  parameter int                    N_EVENTS    = 4,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  address_valid,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [N_EVENTS-1:0]   events,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_level,
  output logic [DATA_WIDTH-1:0] ctrl_pulse,
  output logic                  irq
);

  // Host protocol: a read is requested by address_valid=1 in cycle n and answered on
  // rd_data in cycle n+1; a write is wr_en=1 with address/wr_data in the same cycle.
  // There is no back-pressure: every request is accepted in the cycle it is presented.

  logic [ADDR_WIDTH-1:0]  off;
  logic [4:0]             word;
  logic                   reg_hit;
  logic                   wr_ctrl, wr_pulse, wr_sticky, wr_mask;
  logic [N_EVENTS-1:0]    wr_cnt;
  logic [N_SCRATCH-1:0]   wr_scr;
  logic [DATA_WIDTH-1:0]  rd_next;

  logic [N_EVENTS-1:0]    sticky;
  logic [N_EVENTS-1:0]    irq_mask;
  logic [COUNT_WIDTH-1:0] cnt     [N_EVENTS];
  logic [DATA_WIDTH-1:0]  scratch [N_SCRATCH];

  // Wrapping subtraction: addresses below BASE_ADDR land far outside the 64-byte window.
  assign off     = address - BASE_ADDR;
  assign word    = off[5:1];
  assign reg_hit = (off[ADDR_WIDTH-1:6] == '0) && !off[0];

  always_comb begin
    wr_ctrl   = wr_en && reg_hit && (word == 5'd1);
    wr_pulse  = wr_en && reg_hit && (word == 5'd2);
    wr_sticky = wr_en && reg_hit && (word == 5'd3);
    wr_mask   = wr_en && reg_hit && (word == 5'd4);
    wr_cnt    = '0;
    wr_scr    = '0;
    for (int k = 0; k < N_EVENTS; k++)
      wr_cnt[k] = wr_en && reg_hit && (word == 5'(8 + k));
    for (int k = 0; k < N_SCRATCH; k++)
      wr_scr[k] = wr_en && reg_hit && (word == 5'(24 + k));
  end

  always_comb begin
    rd_next = '0;
    if (address_valid && reg_hit) begin
      case (word)
        5'd0:    rd_next = ID_VALUE;
        5'd1:    rd_next = ctrl_level;
        5'd3:    rd_next = DATA_WIDTH'(sticky);
        5'd4:    rd_next = DATA_WIDTH'(irq_mask);
        5'd5:    rd_next = status_in;
        default: rd_next = '0;
      endcase
      for (int k = 0; k < N_EVENTS; k++)
        if (word == 5'(8 + k)) rd_next = DATA_WIDTH'(cnt[k]);
      for (int k = 0; k < N_SCRATCH; k++)
        if (word == 5'(24 + k)) rd_next = scratch[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data    <= '0;
      ctrl_level <= '0;
      ctrl_pulse <= '0;
      irq        <= 1'b0;
      sticky     <= '0;
      irq_mask   <= '0;
      for (int k = 0; k < N_EVENTS; k++) cnt[k] <= '0;
      for (int k = 0; k < N_SCRATCH; k++) scratch[k] <= '0;
    end else begin
      rd_data    <= rd_next;
      ctrl_pulse <= wr_pulse ? wr_data : '0;
      irq        <= |(sticky & irq_mask);
      if (wr_ctrl) ctrl_level <= wr_data;
      if (wr_mask) irq_mask <= wr_data[N_EVENTS-1:0];
      // A new event beats a same-cycle W1C of the same bit.
      sticky <= events | (sticky & ~(wr_sticky ? wr_data[N_EVENTS-1:0] : '0));
      for (int k = 0; k < N_EVENTS; k++) begin
        if (wr_cnt[k])
          cnt[k] <= events[k] ? COUNT_WIDTH'(1) : '0;
        else if (events[k] && (cnt[k] != '1))
          cnt[k] <= cnt[k] + COUNT_WIDTH'(1);
      end
      for (int k = 0; k < N_SCRATCH; k++)
        if (wr_scr[k]) scratch[k] <= wr_data;
    end
  end

endmodule

// File: tb/tb_gpmc_csr_bank.sv
// Directed bench for gpmc_csr_bank (COUNT_WIDTH=4 so counter saturation is reachable).
module tb_gpmc_csr_bank;

  logic        clk;
  logic        reset_n;
  logic        address_valid;
  logic [15:0] address;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [3:0]  events;
  logic [15:0] status_in;
  logic [15:0] ctrl_level;
  logic [15:0] ctrl_pulse;
  logic        irq;

  int tests_run;
  int tests_failed;

  gpmc_csr_bank #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .BASE_ADDR  (16'h0000),
    .ID_VALUE   (16'hC10D),
    .N_SCRATCH  (2),
    .N_EVENTS   (4),
    .COUNT_WIDTH(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address_valid(address_valid),
    .address      (address),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .events       (events),
    .status_in    (status_in),
    .ctrl_level   (ctrl_level),
    .ctrl_pulse   (ctrl_pulse),
    .irq          (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic idle();
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; address = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; address = '0; wr_data = '0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    address_valid = 1'b1; address = a;
    @(negedge clk);
    address_valid = 1'b0; address = '0;
    check(tag, rd_data, exp);
  endtask

  task automatic pulse_ev(input logic [3:0] m);
    events = m;
    @(negedge clk);
    events = '0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; address_valid = 1'b0; address = '0;
    wr_en = 1'b0; wr_data = '0; events = '0; status_in = 16'h1234;
    repeat (3) idle();
    check("reset_rd_data", rd_data, 16'h0000);
    check("reset_ctrl_level", ctrl_level, 16'h0000);
    check("reset_ctrl_pulse", ctrl_pulse, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    reset_n = 1'b1;

    // 1: reset values and decode window
    rd(16'h0000, 16'hC10D, "rd_id");
    rd(16'h0002, 16'h0000, "rd_ctrl0");
    rd(16'h0006, 16'h0000, "rd_sticky0");
    rd(16'h0010, 16'h0000, "rd_count0");
    rd(16'h0030, 16'h0000, "rd_scratch0");
    rd(16'h0001, 16'h0000, "rd_odd");
    rd(16'h0040, 16'h0000, "rd_out_of_window");
    rd(16'h000A, 16'h1234, "rd_level");
    idle();
    check("rd_idle_zero", rd_data, 16'h0000);

    // 2: scratch and control
    wr(16'h0030, 16'hA5A5);
    wr(16'h0032, 16'h5A5A);
    rd(16'h0030, 16'hA5A5, "rd_scratch0_wr");
    rd(16'h0032, 16'h5A5A, "rd_scratch1_wr");
    wr(16'h0034, 16'h1111);
    rd(16'h0034, 16'h0000, "rd_unimpl_scratch");
    wr(16'h0031, 16'hFFFF);
    rd(16'h0030, 16'hA5A5, "odd_write_ignored");
    wr(16'h0002, 16'h00F0);
    check("ctrl_level_after_wr", ctrl_level, 16'h00F0);
    rd(16'h0002, 16'h00F0, "rd_ctrl");
    // same-cycle read and write return the old value
    address_valid = 1'b1; wr_en = 1'b1; address = 16'h0030; wr_data = 16'h1111;
    @(negedge clk);
    address_valid = 1'b0; wr_en = 1'b0; address = '0; wr_data = '0;
    check("rd_during_wr_old", rd_data, 16'hA5A5);
    rd(16'h0030, 16'h1111, "rd_after_rw");

    // 3: sticky and counters
    repeat (3) pulse_ev(4'b0100);
    rd(16'h0006, 16'h0004, "sticky_set");
    rd(16'h0014, 16'h0003, "count2_three");
    events = 4'b0100; wr_en = 1'b1; address = 16'h0006; wr_data = 16'h0004;
    @(negedge clk);
    events = '0; wr_en = 1'b0; address = '0; wr_data = '0;
    rd(16'h0006, 16'h0004, "sticky_set_wins");
    rd(16'h0014, 16'h0004, "count2_four");
    wr(16'h0006, 16'h0004);
    rd(16'h0006, 16'h0000, "sticky_w1c");

    // 4: interrupt
    wr(16'h0008, 16'h0002);
    rd(16'h0008, 16'h0002, "rd_mask");
    check("irq_idle", {15'd0, irq}, 16'h0000);
    events = 4'b0010;
    @(negedge clk);
    events = '0;
    check("irq_not_yet", {15'd0, irq}, 16'h0000);
    idle();
    check("irq_set", {15'd0, irq}, 16'h0001);
    wr(16'h0008, 16'h0000);
    check("irq_hold_after_unmask", {15'd0, irq}, 16'h0001);
    idle();
    check("irq_cleared", {15'd0, irq}, 16'h0000);
    rd(16'h0006, 16'h0002, "sticky_bit1");

    // 5: counter saturation and clear
    events = 4'b0001;
    repeat (20) @(negedge clk);
    events = '0;
    rd(16'h0010, 16'h000F, "count0_saturated");
    events = 4'b0001; wr_en = 1'b1; address = 16'h0010; wr_data = 16'hFFFF;
    @(negedge clk);
    events = '0; wr_en = 1'b0; address = '0; wr_data = '0;
    rd(16'h0010, 16'h0001, "count0_clear_then_count");
    wr(16'h0010, 16'h0000);
    rd(16'h0010, 16'h0000, "count0_write_clears");
    rd(16'h0012, 16'h0001, "count1_one");

    // 6: pulses and reset
    wr_en = 1'b1; address = 16'h0004; wr_data = 16'h0081;
    @(negedge clk);
    check("pulse_first", ctrl_pulse, 16'h0081);
    @(negedge clk);
    wr_en = 1'b0; address = '0; wr_data = '0;
    check("pulse_second", ctrl_pulse, 16'h0081);
    idle();
    check("pulse_done", ctrl_pulse, 16'h0000);
    rd(16'h0004, 16'h0000, "rd_pulse_wo");
    wr(16'h0008, 16'h0002);
    idle();
    check("irq_before_reset", {15'd0, irq}, 16'h0001);

    wr_en = 1'b1; address = 16'h0004; wr_data = 16'h0081;
    @(negedge clk);
    check("pulse_before_reset", ctrl_pulse, 16'h0081);
    reset_n = 1'b0; events = 4'hF;
    address_valid = 1'b1; address = 16'h0030; wr_data = 16'hFFFF;
    @(negedge clk);
    reset_n = 1'b1; events = '0; wr_en = 1'b0; address_valid = 1'b0;
    address = '0; wr_data = '0;
    check("rst_pulse_killed", ctrl_pulse, 16'h0000);
    check("rst_ctrl_level", ctrl_level, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_rd_data", rd_data, 16'h0000);
    rd(16'h0002, 16'h0000, "post_rst_ctrl");
    rd(16'h0006, 16'h0000, "post_rst_sticky");
    rd(16'h0008, 16'h0000, "post_rst_mask");
    rd(16'h0010, 16'h0000, "post_rst_count0");
    rd(16'h0012, 16'h0000, "post_rst_count1");
    rd(16'h0014, 16'h0000, "post_rst_count2");
    rd(16'h0030, 16'h0000, "post_rst_scratch0");
    rd(16'h0032, 16'h0000, "post_rst_scratch1");
    rd(16'h0000, 16'hC10D, "post_rst_id");

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
